// File: rtl/dpi_mem_burst_reader.sv
// dpi_mem_burst_reader
// Burst read engine in front of the C++ memory model. It takes a base address
// and a beat count, issues one DATA_W-wide beat per cycle, and reads one 64-bit
// lane per dpi_read_ram call. Each result is held back LATENCY cycles before it
// becomes visible on the rsp_* channel.
//
// Each issued beat claims a response slot at issue time, so the slot count is
// the credit pool. Every slot carries a countdown that models the fixed read
// latency. A slot becomes visible at the FIFO head when its countdown reaches
// zero. Because of this, pipeline occupancy plus FIFO occupancy is simply the
// number of claimed slots.
//
// Build options:
//   DPI_MEM_STATS_EN     adds the stat_beats / stat_stalls saturating counters.
// The memory model is an in-module function returning
// address ^ 0xA5A5_A5A5_A5A5_A5A5.
module dpi_mem_burst_reader #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy
`ifdef DPI_MEM_STATS_EN
    ,
    output logic [31:0]       stat_beats,
    output logic [31:0]       stat_stalls
`endif
);

    localparam int LANES      = DATA_W / 64;
    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW         = $clog2(DEPTH + 1);
    localparam int WW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [WW-1:0] LAT_M1    = WW'(LATENCY - 1);

    function automatic longint dpi_read_ram(input longint a);
        return a ^ 64'hA5A5_A5A5_A5A5_A5A5;
    endfunction

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic [63:0]       beat_addr;

    logic [DATA_W-1:0] slot_data [DEPTH];
    logic [DEPTH-1:0]  slot_last;
    logic [WW-1:0]     slot_wait [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     slot_cnt;

    logic              issue;
    logic              last_beat;
    logic              rsp_fire;

    // A beat goes out only in ISSUE with a free slot. Nothing issues during
    // reset, so no DPI call can happen while rst_n is low.
    assign issue     = rst_n && (state == ISSUE) && (slot_cnt < DEPTH_C);
    assign last_beat = (beat_cnt == len_q);
    assign rsp_fire  = rsp_valid && rsp_ready;

    assign req_ready = rst_n && (state == IDLE);
    assign busy      = (state == ISSUE) || (slot_cnt != '0);

    // The head slot is presented only after its latency countdown has expired.
    // Outputs read zero whenever nothing is valid.
    assign rsp_valid = (slot_cnt != '0) && (slot_wait[rd_ptr] == '0);
    assign rsp_data  = rsp_valid ? slot_data[rd_ptr] : '0;
    assign rsp_last  = rsp_valid && slot_last[rd_ptr];

    // Request FSM: latch a burst in IDLE, walk its beats in ISSUE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= ISSUE;
                        len_q     <= req_len;
                        beat_addr <= 64'(req_addr);
                        beat_cnt  <= '0;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        beat_cnt  <= beat_cnt + 1'b1;
                        beat_addr <= beat_addr + 64'(BEAT_BYTES);
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slot bookkeeping. A slot is claimed on issue and freed on the rsp
    // handshake, so a freed credit can be reused from the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            slot_cnt <= '0;
        end else begin
            if (issue) begin
                wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
            end
            if (rsp_fire) begin
                rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
            end
            case ({issue, rsp_fire})
                2'b10:   slot_cnt <= slot_cnt + 1'b1;
                2'b01:   slot_cnt <= slot_cnt - 1'b1;
                default: slot_cnt <= slot_cnt;
            endcase
        end
    end

    // Latency countdown per slot. A newly issued beat starts at LATENCY-1, so
    // it reaches the head at the earliest LATENCY cycles after its issue edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_wait[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_wait[i] != '0) begin
                    slot_wait[i] <= slot_wait[i] - 1'b1;
                end
            end
            if (issue) begin
                slot_wait[wr_ptr] <= LAT_M1;
            end
        end
    end

    // Lane reads: exactly one model call per 64-bit lane, only on an issue edge.
    // Lane j reads beat_addr + 8*j, and the address wraps modulo 2^64.
    always_ff @(posedge clk) begin
        if (issue) begin
            for (int j = 0; j < LANES; j++) begin
                slot_data[wr_ptr][j*64 +: 64] <= dpi_read_ram(beat_addr + 64'(8 * j));
            end
            slot_last[wr_ptr] <= last_beat;
        end
    end

`ifdef DPI_MEM_STATS_EN
    logic stall;

    assign stall = (state == ISSUE) && (slot_cnt == DEPTH_C);

    // Saturating counters for delivered beats and credit-starved ISSUE cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else begin
            if (rsp_fire && (stat_beats != 32'hFFFF_FFFF)) begin
                stat_beats <= stat_beats + 1'b1;
            end
            if (stall && (stat_stalls != 32'hFFFF_FFFF)) begin
                stat_stalls <= stat_stalls + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/dpi_mem_burst_reader.md
Name: dpi_mem_burst_reader

Overview:
- Parametrised successor to the single-word DPI RAM read port: burst read engine for the C++ memory model.
- Accepts a base address and beat count over a valid/ready request channel.
- Issues one wide beat per cycle via `dpi_read_ram` (one call per 64-bit lane), delays results through a fixed-latency pipeline and buffers them in a credit-protected response FIFO.
- Sits between compute/test sequencers and the C++ model (`longint dpi_read_ram(input longint a)`).

Parameters:
- ADDR_W, 64, address width; the address is zero-extended to 64 bits for DPI.
- DATA_W, 64, beat width; must be a multiple of 64; LANES = DATA_W/64.
- LATENCY, 2, cycles from beat issue to earliest rsp_valid; legal range 1..8.
- DEPTH, 4, response FIFO entries; must be ≥ LATENCY.
- LEN_W, 4, width of the burst-length field.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  byte base address.
- req_len  in  LEN_W  beats minus 1.
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  consumer accepts the beat.
- rsp_data  out  DATA_W  beat data; lane 0 in the LSBs.
- rsp_last  out  1  final beat of its burst.
- busy  out  1  burst issuing, or beats in pipeline/FIFO.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; req_ready=0 during reset; rsp_valid=0, rsp_data=0, rsp_last=0, busy=0.
  - Pipeline and FIFO are flushed and credits restored to DEPTH.
  - No DPI calls occur while rst_n=0.
  - Reset mid-burst discards all remaining and in-flight beats.
- FSM, IDLE:
  - req_ready=1.
  - On accept, latch addr/len, set beat counter to 0, go to ISSUE.
- FSM, ISSUE:
  - req_ready=0.
  - Issue a beat when credits > 0, where credits = DEPTH − (pipeline occupancy + FIFO occupancy).
  - On the last issued beat (counter == len), return to IDLE in the next cycle.
  - A new request may then be accepted while earlier beats still drain.
- Beat issue, beat k:
  - Lane j address = base + k*(DATA_W/8) + 8*j, modulo 2^64 (wraps silently).
  - Each issued beat makes exactly one DPI call per lane, in the issue cycle.
  - Beats are never called twice or dropped.
- First beat: issued in the cycle after acceptance.
  - No stalls: beat k issued at T+1+k.
  - rsp_valid for beat k at T+1+k+LATENCY.
- Response channel:
  - FIFO head drives rsp_*.
  - rsp_data, rsp_last and rsp_valid hold stable while rsp_valid && !rsp_ready.
  - Simultaneous FIFO push and pop is allowed at any occupancy.
- Credits: a credit returns on the rsp handshake, so FIFO overflow is impossible.
- Stall cycle = ISSUE state with credits = 0; issue resumes in the cycle after a credit returns.
- rsp_last is set on beat len of each burst.
- busy = (state == ISSUE) || pipeline nonempty || FIFO nonempty.
- req_len = 0 gives a single-beat burst with rsp_last=1.

Optional Feature:
- Macro: DPI_MEM_STATS_EN.
- When defined, adds two outputs:
  - stat_beats (32, out): count of rsp handshakes.
  - stat_stalls (32, out): count of stall cycles.
- Both counters reset to 0 and saturate at 0xFFFFFFFF.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single beat:
  - Model RAM[a] = a ^ 0xA5A5…; req_addr = 0x100, len = 0, rsp_ready = 1.
  - Expect one beat at accept+1+LATENCY; data = 0x100 ^ pattern; rsp_last = 1; busy then drops.
- Burst, DATA_W = 128:
  - len = 3, addr = 0x1000.
  - Expect 4 back-to-back beats with lane addresses 0x1000/0x1008 … 0x1030/0x1038; rsp_last only on beat 3.
  - Exactly 8 DPI calls.
- Backpressure:
  - DEPTH = 4, len = 7, rsp_ready = 0 for 20 cycles.
  - Expect issue to halt after 4 beats and rsp_data held stable.
  - Release rsp_ready: all 8 beats arrive in order, no duplicate DPI calls.
  - With DPI_MEM_STATS_EN: stat_stalls ≥ 16, stat_beats = 8.
- Address wrap:
  - addr = 0xFFFF_FFFF_FFFF_FFF8, len = 1, DATA_W = 64.
  - Expect beat addresses 0x…FFF8 then 0x0.
- Reset mid-burst:
  - Assert rst_n = 0 for 1 cycle after 2 of 8 beats delivered.
  - Expect rsp_valid = 0 next cycle, busy = 0, FIFO empty, no further DPI calls.
  - A new request is accepted once rst_n = 1.
- Back-to-back requests:
  - Two len = 1 bursts, the second presented while the first drains.
  - Expect 4 beats in order, with rsp_last on beats 1 and 3.
